// File: rtl/stopwatch_dp_if.sv
// Command/count bundle between the stopwatch control unit, this datapath and the display formatter.
// The datapath takes the slave side; the controller and formatter see the master side.
interface stopwatch_dp_if;
    logic       i_run;
    logic       i_clear;
    logic [6:0] o_msec;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;
    logic       o_tick;
    logic       o_rollover;

    modport slave (
        input  i_run, i_clear,
        output o_msec, o_sec, o_min, o_hour, o_tick, o_rollover
    );

    modport master (
        output i_run, i_clear,
        input  o_msec, o_sec, o_min, o_hour, o_tick, o_rollover
    );
endinterface

// File: rtl/stopwatch_dp.sv
// Stopwatch datapath: prescaler down to TICK_HZ and a cascaded cs/s/min/h counter chain.
// Priority per edge: reset > clear > run > hold. All outputs come straight from registers.
module stopwatch_dp #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned TICK_HZ  = 100,
    parameter int unsigned DIV      = CLK_FREQ / TICK_HZ
) (
    input  logic            clk,
    input  logic            reset,
    stopwatch_dp_if.slave   sw
);

    localparam int unsigned     CntW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] DivMax = CntW'(DIV - 1);

    logic [CntW-1:0] div_cnt_q, div_cnt_d;
    logic [6:0]      msec_q, msec_d;
    logic [5:0]      sec_q, sec_d;
    logic [5:0]      min_q, min_d;
    logic [4:0]      hour_q, hour_d;
    logic            tick_q, tick_d;
    logic            roll_q, roll_d;

    always_comb begin
        div_cnt_d = div_cnt_q;
        msec_d    = msec_q;
        sec_d     = sec_q;
        min_d     = min_q;
        hour_d    = hour_q;
        tick_d    = 1'b0;
        roll_d    = 1'b0;

        if (sw.i_clear) begin
            div_cnt_d = '0;
            msec_d    = '0;
            sec_d     = '0;
            min_d     = '0;
            hour_d    = '0;
        end else if (sw.i_run) begin
            if (div_cnt_q == DivMax) begin
                div_cnt_d = '0;
                tick_d    = 1'b1;
                // Every carry is resolved in this one cycle; each field wraps at its own max.
                if (msec_q == 7'd99) begin
                    msec_d = '0;
                    if (sec_q == 6'd59) begin
                        sec_d = '0;
                        if (min_q == 6'd59) begin
                            min_d = '0;
                            if (hour_q == 5'd23) begin
                                hour_d = '0;
                                roll_d = 1'b1;
                            end else begin
                                hour_d = hour_q + 5'd1;
                            end
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end else begin
                    msec_d = msec_q + 7'd1;
                end
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
            msec_q    <= '0;
            sec_q     <= '0;
            min_q     <= '0;
            hour_q    <= '0;
            tick_q    <= 1'b0;
            roll_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            msec_q    <= msec_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            hour_q    <= hour_d;
            tick_q    <= tick_d;
            roll_q    <= roll_d;
        end
    end

    assign sw.o_msec     = msec_q;
    assign sw.o_sec      = sec_q;
    assign sw.o_min      = min_q;
    assign sw.o_hour     = hour_q;
    assign sw.o_tick     = tick_q;
    assign sw.o_rollover = roll_q;

endmodule

// File: tb/tb_stopwatch_dp.sv
// Bench for stopwatch_dp at DIV=4: a total-centisecond model checked every cycle,
// plus literal expectations at the interesting points.
module tb_stopwatch_dp;

    localparam int DIV = 4;
    localparam int DAY = 24 * 60 * 60 * 100;

    logic clk;
    logic reset;

    stopwatch_dp_if sw ();

    stopwatch_dp #(
        .DIV (DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: elapsed centiseconds since 00:00:00.00 and prescaler phase.
    int m_cs;
    int m_ph;
    int m_tick;
    int m_roll;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".msec"}, int'(sw.o_msec), m_cs % 100);
        chk({tag, ".sec"},  int'(sw.o_sec),  (m_cs / 100) % 60);
        chk({tag, ".min"},  int'(sw.o_min),  (m_cs / 6000) % 60);
        chk({tag, ".hour"}, int'(sw.o_hour), (m_cs / 360000) % 24);
        chk({tag, ".tick"}, int'(sw.o_tick), m_tick);
        chk({tag, ".roll"}, int'(sw.o_rollover), m_roll);
        chk({tag, ".range"}, int'(sw.o_msec <= 7'd99 && sw.o_sec <= 6'd59 &&
                                  sw.o_min <= 6'd59 && sw.o_hour <= 5'd23), 1);
    endtask

    // One clock: advance the model on the edge, compare on the falling edge.
    task automatic step();
        @(posedge clk);
        m_tick = 0;
        m_roll = 0;
        if (sw.i_clear) begin
            m_cs = 0;
            m_ph = 0;
        end else if (sw.i_run) begin
            if (m_ph == DIV - 1) begin
                m_ph   = 0;
                m_tick = 1;
                m_cs   = m_cs + 1;
                if (m_cs == DAY) begin
                    m_cs   = 0;
                    m_roll = 1;
                end
            end else begin
                m_ph = m_ph + 1;
            end
        end
        @(negedge clk);
        compare_all("cyc");
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Load a time and prescaler phase directly into the counter registers (call with run=0).
    task automatic preload(input int h, input int m, input int s, input int c, input int ph);
        dut.hour_q    = 5'(h);
        dut.min_q     = 6'(m);
        dut.sec_q     = 6'(s);
        dut.msec_q    = 7'(c);
        dut.div_cnt_q = 2'(ph);
        m_cs = ((h * 60 + m) * 60 + s) * 100 + c;
        m_ph = ph;
        #1;
        compare_all("preload");
    endtask

    task automatic lit(input string tag, input int h, input int m, input int s, input int c,
                       input int tick, input int roll);
        chk({tag, ".hour"}, int'(sw.o_hour), h);
        chk({tag, ".min"},  int'(sw.o_min),  m);
        chk({tag, ".sec"},  int'(sw.o_sec),  s);
        chk({tag, ".msec"}, int'(sw.o_msec), c);
        chk({tag, ".tick"}, int'(sw.o_tick), tick);
        chk({tag, ".roll"}, int'(sw.o_rollover), roll);
    endtask

    initial begin
        int ticks;
        int last;

        reset      = 1'b1;
        sw.i_run   = 1'b0;
        sw.i_clear = 1'b0;
        m_cs = 0; m_ph = 0; m_tick = 0; m_roll = 0;
        @(negedge clk);
        @(negedge clk);
        lit("reset", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // Basic count: 400 cycles at DIV=4 is 100 ticks = 1 s.
        sw.i_clear = 1'b1;
        step();
        sw.i_clear = 1'b0;
        sw.i_run   = 1'b1;
        ticks = 0;
        last  = -1;
        for (int i = 0; i < 400; i++) begin
            step();
            if (sw.o_tick) begin
                if (last >= 0) chk("tick_gap", i - last, 4);
                last = i;
                ticks++;
            end
        end
        chk("basic.ticks", ticks, 100);
        lit("basic", 0, 0, 1, 0, 1, 0);

        // Async reset mid-count at 00:00:01.37.
        steps(137 * DIV);
        lit("pre_reset", 0, 0, 2, 37, 1, 0);
        sw.i_clear = 1'b1;
        step();
        sw.i_clear = 1'b0;
        steps(137 * DIV);
        lit("pre_reset2", 0, 0, 1, 37, 1, 0);
        #1;
        reset = 1'b1;
        #1;
        lit("async_reset", 0, 0, 0, 0, 0, 0);
        m_cs = 0; m_ph = 0; m_tick = 0; m_roll = 0;
        #1;
        reset = 1'b0;
        sw.i_run = 1'b0;
        step();

        // Pause/resume keeps the partial prescaler count.
        sw.i_run = 1'b1;
        steps(6);
        lit("pause.run6", 0, 0, 0, 1, 0, 0);
        sw.i_run = 1'b0;
        steps(50);
        lit("pause.held", 0, 0, 0, 1, 0, 0);
        sw.i_run = 1'b1;
        step();
        lit("resume+1", 0, 0, 0, 1, 0, 0);
        step();
        lit("resume+2", 0, 0, 0, 2, 1, 0);

        // Run dropped on the tick edge: tick not counted.
        steps(3);
        sw.i_run = 1'b0;
        step();
        lit("run_drop", 0, 0, 0, 2, 0, 0);

        // Cascade and rollover from 23:59:59.98.
        preload(23, 59, 59, 98, 0);
        sw.i_run = 1'b1;
        steps(4);
        lit("roll+4", 23, 59, 59, 99, 1, 0);
        steps(4);
        lit("roll+8", 0, 0, 0, 0, 1, 1);
        step();
        lit("roll+9", 0, 0, 0, 0, 0, 0);

        // Clear beats run on a tick edge at 00:12:34.56.
        sw.i_run = 1'b0;
        step();
        preload(0, 12, 34, 56, DIV - 1);
        sw.i_run   = 1'b1;
        sw.i_clear = 1'b1;
        step();
        lit("clear_tick", 0, 0, 0, 0, 0, 0);
        step();
        lit("clear_held", 0, 0, 0, 0, 0, 0);
        sw.i_clear = 1'b0;
        steps(3);
        lit("after_clear+3", 0, 0, 0, 0, 0, 0);
        step();
        lit("after_clear+4", 0, 0, 0, 1, 1, 0);

        // Field boundaries.
        sw.i_run = 1'b0;
        step();
        preload(0, 0, 59, 99, DIV - 1);
        sw.i_run = 1'b1;
        step();
        lit("sec_wrap", 0, 1, 0, 0, 1, 0);
        sw.i_run = 1'b0;
        step();
        preload(0, 59, 59, 99, DIV - 1);
        sw.i_run = 1'b1;
        step();
        lit("min_wrap", 1, 0, 0, 0, 1, 0);
        steps(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
